// File: rtl/alu_sequencer.sv
// Multi-cycle Moore control sequencer for the bus-based ALU datapath.
// Steps fetch (with memory wait) and the execute transfers per opcode class.
module alu_sequencer #(
  parameter int              OP_W    = 5,
  parameter logic [OP_W-1:0] OP_NOP  = 5'b11001,
  parameter logic [OP_W-1:0] OP_HALT = 5'b11010
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            Cout,
  output logic            MARin,
  output logic            PCin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            MDRin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [OP_W-1:0] alu_op,
  output logic            run
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3,
    S_E1, S_E2, S_E3, S_E4,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R3, C_IMM, C_MD, C_UN, C_NOP, C_HALT
  } cls_t;

  state_t          state, state_n;
  cls_t            cls;
  logic [OP_W-1:0] op;
  logic            unused_ir;

  assign op        = ir[31 -: OP_W];
  assign unused_ir = ^ir[31-OP_W:0];

  always_comb begin
    cls = C_NOP;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = C_R3;
      5'b01100, 5'b01101, 5'b01110:           cls = C_IMM;
      5'b01111, 5'b10000:                     cls = C_MD;
      5'b10001, 5'b10010:                     cls = C_UN;
      OP_NOP:                                 cls = C_NOP;
      OP_HALT:                                cls = C_HALT;
      default:                                cls = C_NOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state <= S_T0;
    else       state <= state_n;
  end

  // clear masks every output so nothing is written back mid-instruction
  always_comb begin
    state_n  = state;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    MDRin    = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = '0;
    run      = 1'b1;
    if (clear) begin
      state_n = S_T0;
    end else begin
      case (state)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1;
          IncPC = 1'b1; Zin   = 1'b1;
          state_n = S_T1;
        end
        S_T1: begin
          Zlowout = 1'b1; PCin = 1'b1;
          state_n = S_T2;
        end
        S_T2: begin
          Read = 1'b1; MDRin = 1'b1;
          if (mem_ready) state_n = S_T3;
        end
        S_T3: begin
          MDRout = 1'b1; IRin = 1'b1;
          state_n = S_E1;
        end
        S_E1: begin
          state_n = S_T0;
          case (cls)
            C_R3, C_IMM: begin
              Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
              state_n = S_E2;
            end
            C_MD: begin
              Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
              state_n = S_E2;
            end
            C_UN: begin
              Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
              alu_op = op;
              state_n = S_E2;
            end
            C_HALT:  state_n = S_HALT;
            default: state_n = S_T0;
          endcase
        end
        S_E2: begin
          state_n = S_T0;
          case (cls)
            C_R3: begin
              Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
              alu_op = op;
              state_n = S_E3;
            end
            C_IMM: begin
              Cout = 1'b1; Zin = 1'b1;
              alu_op = op;
              state_n = S_E3;
            end
            C_MD: begin
              Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
              alu_op = op;
              state_n = S_E3;
            end
            C_UN: begin
              Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            default: state_n = S_T0;
          endcase
        end
        S_E3: begin
          state_n = S_T0;
          case (cls)
            C_R3, C_IMM: begin
              Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            C_MD: begin
              Zlowout = 1'b1; LOin = 1'b1;
              state_n = S_E4;
            end
            default: state_n = S_T0;
          endcase
        end
        S_E4: begin
          Zhighout = 1'b1; HIin = 1'b1;
          state_n = S_T0;
        end
        S_HALT: run = 1'b0;
        default: state_n = S_T0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: per-cycle expected strobe words built from
// the instruction-level transfer tables, compared every cycle.
module tb_alu_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic PCout, Zlowout, Zhighout, MDRout, Cout;
  logic MARin, PCin, IRin, Yin, Zin, MDRin, HIin, LOin;
  logic IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  alu_op;
  logic        run;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .Cout(Cout), .MARin(MARin), .PCin(PCin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  localparam logic [19:0] PCOUT    = 20'b1 << 0;
  localparam logic [19:0] ZLOWOUT  = 20'b1 << 1;
  localparam logic [19:0] ZHIGHOUT = 20'b1 << 2;
  localparam logic [19:0] MDROUT   = 20'b1 << 3;
  localparam logic [19:0] COUT     = 20'b1 << 4;
  localparam logic [19:0] ROUT     = 20'b1 << 5;
  localparam logic [19:0] MARIN    = 20'b1 << 6;
  localparam logic [19:0] PCIN     = 20'b1 << 7;
  localparam logic [19:0] IRIN     = 20'b1 << 8;
  localparam logic [19:0] YIN      = 20'b1 << 9;
  localparam logic [19:0] ZIN      = 20'b1 << 10;
  localparam logic [19:0] MDRIN    = 20'b1 << 11;
  localparam logic [19:0] HIIN     = 20'b1 << 12;
  localparam logic [19:0] LOIN     = 20'b1 << 13;
  localparam logic [19:0] INCPC    = 20'b1 << 14;
  localparam logic [19:0] READ     = 20'b1 << 15;
  localparam logic [19:0] GRA      = 20'b1 << 16;
  localparam logic [19:0] GRB      = 20'b1 << 17;
  localparam logic [19:0] GRC      = 20'b1 << 18;
  localparam logic [19:0] RIN      = 20'b1 << 19;

  localparam logic [25:0] W_CLEAR  = {5'b0, 1'b1, 20'b0};
  localparam logic [25:0] W_HALTED = {5'b0, 1'b0, 20'b0};

  logic [19:0] obs_mask;
  logic [25:0] obs;
  assign obs_mask = {Rin, Grc, Grb, Gra, Read, IncPC, LOin, HIin,
                     MDRin, Zin, Yin, IRin, PCin, MARin, Rout, Cout,
                     MDRout, Zhighout, Zlowout, PCout};
  assign obs = {alu_op, run, obs_mask};

  logic [25:0] exp_q[$];
  logic [31:0] ir_q[$];
  logic        mr_q[$];
  logic        clr_q[$];

  function automatic logic [25:0] w(input logic [19:0] m,
                                    input logic [4:0] op);
    return {op, 1'b1, m};
  endfunction

  function automatic void push(input logic [25:0] e, input logic [31:0] i,
                               input logic mr, input logic c);
    exp_q.push_back(e);
    ir_q.push_back(i);
    mr_q.push_back(mr);
    clr_q.push_back(c);
  endfunction

  function automatic void drop_last();
    void'(exp_q.pop_back());
    void'(ir_q.pop_back());
    void'(mr_q.pop_back());
    void'(clr_q.pop_back());
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Fetch: ir is garbage until E1, mem_ready only matters in T2
  function automatic void add_fetch(input int waits);
    push(w(PCOUT | MARIN | INCPC | ZIN, 5'd0), $urandom, rbit(), 1'b0);
    push(w(ZLOWOUT | PCIN, 5'd0), $urandom, rbit(), 1'b0);
    for (int k = 0; k < waits; k++)
      push(w(READ | MDRIN, 5'd0), $urandom, 1'b0, 1'b0);
    push(w(READ | MDRIN, 5'd0), $urandom, 1'b1, 1'b0);
    push(w(MDROUT | IRIN, 5'd0), $urandom, rbit(), 1'b0);
  endfunction

  function automatic void add_exec(input logic [31:0] instr);
    logic [4:0] op;
    op = instr[31:27];
    if (op inside {5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11}) begin
      push(w(GRB | ROUT | YIN, 5'd0), instr, rbit(), 1'b0);
      push(w(GRC | ROUT | ZIN, op), instr, rbit(), 1'b0);
      push(w(ZLOWOUT | GRA | RIN, 5'd0), instr, rbit(), 1'b0);
    end else if (op inside {5'd12, 5'd13, 5'd14}) begin
      push(w(GRB | ROUT | YIN, 5'd0), instr, rbit(), 1'b0);
      push(w(COUT | ZIN, op), instr, rbit(), 1'b0);
      push(w(ZLOWOUT | GRA | RIN, 5'd0), instr, rbit(), 1'b0);
    end else if (op inside {5'd15, 5'd16}) begin
      push(w(GRA | ROUT | YIN, 5'd0), instr, rbit(), 1'b0);
      push(w(GRB | ROUT | ZIN, op), instr, rbit(), 1'b0);
      push(w(ZLOWOUT | LOIN, 5'd0), instr, rbit(), 1'b0);
      push(w(ZHIGHOUT | HIIN, 5'd0), instr, rbit(), 1'b0);
    end else if (op inside {5'd17, 5'd18}) begin
      push(w(GRB | ROUT | ZIN, op), instr, rbit(), 1'b0);
      push(w(ZLOWOUT | GRA | RIN, 5'd0), instr, rbit(), 1'b0);
    end else begin
      push(w(20'b0, 5'd0), instr, rbit(), 1'b0);
    end
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = op;
    return r;
  endfunction

  task automatic play(input string tag);
    logic [25:0] e;
    while (exp_q.size() > 0) begin
      @(posedge clock); #1;
      clear     = clr_q.pop_front();
      ir        = ir_q.pop_front();
      mem_ready = mr_q.pop_front();
      e         = exp_q.pop_front();
      @(negedge clock);
      cyc++;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, obs, e);
      end
      checks++;
      if ($countones(obs_mask[5:0]) > 1) begin
        errors++;
        $display("FAIL %s_bus cycle %0d drivers %b expected at most one",
                 tag, cyc, obs_mask[5:0]);
      end
    end
  endtask

  task automatic test_reset();
    push(W_CLEAR, $urandom, rbit(), 1'b1);
    push(W_CLEAR, $urandom, rbit(), 1'b1);
    add_fetch(0);
    add_exec(mk(5'b01010));
    drop_last();
    drop_last();
    push(W_CLEAR, $urandom, rbit(), 1'b1);
    push(W_CLEAR, $urandom, rbit(), 1'b1);
    play("reset");
  endtask

  task automatic test_and();
    add_fetch(0);
    add_exec(32'h5091_8000);
    play("and");
  endtask

  task automatic test_mem_wait();
    add_fetch(3);
    add_exec(mk(5'b00011));
    play("mem_wait");
  endtask

  task automatic test_mul();
    add_fetch(int'($urandom_range(0, 2)));
    add_exec(mk(5'b01111));
    play("mul");
  endtask

  task automatic test_mixed();
    add_fetch(1);
    add_exec(mk(5'b01110));
    add_fetch(0);
    add_exec(mk(5'b10010));
    add_fetch(2);
    add_exec(mk(5'b11111));
    play("mixed");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 40; n++) begin
      do op = 5'($urandom); while (op == 5'b11010);
      add_fetch(int'($urandom_range(0, 4)));
      add_exec(mk(op));
    end
    play("random");
  endtask

  task automatic test_halt();
    add_fetch(1);
    add_exec(mk(5'b11010));
    for (int k = 0; k < 25; k++)
      push(W_HALTED, $urandom, rbit(), 1'b0);
    push(W_CLEAR, $urandom, rbit(), 1'b1);
    add_fetch(0);
    add_exec(mk(5'b11001));
    play("halt");
  endtask

  initial begin
    clock     = 1'b0;
    clear     = 1'b1;
    ir        = '0;
    mem_ready = 1'b0;
    test_reset();
    test_and();
    test_mem_wait();
    test_mul();
    test_mixed();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Moore-style multi-cycle control sequencer for the bus-based datapath built around the ALU, the Y/Z registers, PC, MAR/MDR, IR and HI/LO.
- Fetches an instruction, waits on memory with a ready handshake, then steps the register-transfer cycles for ALU-class instructions.
- Per-cycle outputs are the datapath strobes and the ALU opcode.
- Sits between IR/memory and the datapath strobe inputs.

Parameters:
- OP_W, 5, opcode width (ir[31:27]).
- OP_NOP, 5'b11001, no-operation opcode.
- OP_HALT, 5'b11010, halt opcode.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  synchronous active-high reset.
- ir  in  32  instruction register contents; opcode = ir[31:27].
- mem_ready  in  1  memory read data valid on MDR input this cycle.
- PCout, Zlowout, Zhighout, MDRout, Cout  out  1 each  bus-drive strobes.
- MARin, PCin, IRin, Yin, Zin, MDRin, HIin, LOin  out  1 each  register load strobes.
- IncPC  out  1  ALU computes PC+1 this cycle.
- Read  out  1  memory read request / MDR source select.
- Gra, Grb, Grc, Rin, Rout  out  1 each  select/encode register-field strobes.
- alu_op  out  OP_W  opcode presented to ALU.
- run  out  1  1 = executing, 0 = halted.

Behaviour:
- Only stored state is the state register. All outputs decode from state and ir.
- While clear=1: every strobe = 0, alu_op = 0, run = 1, and the state loads T0 at the clock edge. Clear takes effect from any state, including mid-execute, HALT and a memory wait, with no partial writeback afterwards.
- Strobes not listed for a state are 0.
- alu_op = ir[31:27] in states that assert Zin during execute; otherwise 0.
- Fetch states:
  - T0: PCout, MARin, IncPC, Zin. Next: T1.
  - T1: Zlowout, PCin. Next: T2.
  - T2: Read, MDRin, held every cycle until mem_ready=1. Then T3. No timeout.
  - T3: MDRout, IRin. Next: E1. ir is valid from E1 onward.
- Classes, decoded from ir[31:27] in E1..E4:
  - R3: add 00011, sub 00100, shr 00101, shl 00111, ror 01000, rol 01001, and 01010, or 01011.
  - IMM: addi 01100, andi 01101, ori 01110.
  - MD: mul 01111, div 10000.
  - UN: neg 10001, not 10010.
  - OP_NOP, OP_HALT.
  - Any other opcode is treated as NOP.
- Execute sequences:
  - R3: E1 Grb,Rout,Yin; E2 Grc,Rout,Zin; E3 Zlowout,Gra,Rin; then T0.
  - IMM: E1 Grb,Rout,Yin; E2 Cout,Zin; E3 Zlowout,Gra,Rin; then T0.
  - MD: E1 Gra,Rout,Yin; E2 Grb,Rout,Zin; E3 Zlowout,LOin; E4 Zhighout,HIin; then T0.
  - UN: E1 Grb,Rout,Zin; E2 Zlowout,Gra,Rin; then T0.
  - NOP: E1 with no strobes; then T0.
  - HALT: E1 with no strobes; then HALT.
- HALT state: all strobes 0, run=0. Exit only via clear.
- Instruction latency:
  - fetch = 4 cycles + (cycles in T2 with mem_ready=0);
  - execute: R3/IMM 3, MD 4, UN 2, NOP 1.
- Exactly one bus-drive strobe (PCout, Zlowout, Zhighout, MDRout, Cout, Rout) is active per cycle, or none. The bench must assert this as an invariant.
- mem_ready outside T2 is ignored.
- ir changes outside E-states do not affect outputs, except alu_op, which is 0 outside E-states anyway.

Test Plan:
- Reset: clear=1 for 2 cycles in mid-E2 of an R3 op -> all strobes 0 during clear; first cycle after release is T0 (PCout=MARin=IncPC=Zin=1); no Rin pulse ever seen.
- and R1,R2,R3 (ir=0x50918000), mem_ready high on first T2 cycle -> 7 cycles, T0..T3 then E1 Grb/Rout/Yin, E2 Grc/Rout/Zin with alu_op=01010, E3 Zlowout/Gra/Rin; next cycle T0.
- Memory wait: mem_ready low for 3 cycles in T2 -> Read=MDRin=1 for 4 cycles; IRin exactly one cycle after mem_ready rises; PCin pulsed exactly once.
- mul (opcode 01111) -> E2 alu_op=01111 with Zin; E3 LOin+Zlowout; E4 HIin+Zhighout; Rin never asserted.
- ori, then not, then opcode 11111 -> ori E2 Cout+Zin; not E1 Zin with alu_op=10010 and no Yin; 11111 gives one idle E1 then T0.
- halt (11010) -> run=0 and all strobes 0 for 20+ cycles regardless of mem_ready; clear then returns to T0 with run=1.
